// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle.
// Groups the memory fetch port (pc / instrIn), the hazard and branch controls
// (stall, redirect, redirectTarget) and the IF/ID pipeline register outputs.
//   master : the fetch stage itself
//   slave  : its environment (memory, hazard unit, decode)
interface instruction_fetch_if #(
  parameter int n = 32,
  parameter int m = 6
);
  logic [m-1:0] pc;
  logic [n-1:0] instrIn;
  logic         stall;
  logic         redirect;
  logic [m-1:0] redirectTarget;
  logic [n-1:0] ifidInstr;
  logic [m-1:0] ifidPc;
  logic         ifidValid;
  logic         halted;

  modport master (
    output pc, ifidInstr, ifidPc, ifidValid, halted,
    input  instrIn, stall, redirect, redirectTarget
  );

  modport slave (
    input  pc, ifidInstr, ifidPc, ifidValid, halted,
    output instrIn, stall, redirect, redirectTarget
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction-fetch stage.
// Drives the fetch address of an asynchronous-read memory and latches the
// returned word into the IF/ID register. Handles hazard stalls, branch/jump
// redirects and the end-of-program word (opcode all ones), after which it
// issues drainCycles bubbles and then parks in a sticky halted state.
// Ports:
//   Clk  : clock, all state on posedge
//   Rst  : synchronous active-high reset
//   bus  : instruction_fetch_if master (pc, instrIn, stall, redirect,
//          redirectTarget, ifidInstr, ifidPc, ifidValid, halted)
// Every output comes straight from a flop.
module instruction_fetch #(
  parameter int n           = 32,
  parameter int m           = 6,
  parameter int drainCycles = 4
) (
  input  logic                 Clk,
  input  logic                 Rst,
  instruction_fetch_if.master  bus
);

  typedef enum logic [1:0] {sRun, sDrain, sHalted} fetchStateT;

  typedef struct packed {
    logic [n-1:0] instr;
    logic [m-1:0] pcPlus1;
    logic         valid;
  } ifidT;

  localparam logic [5:0]   HaltOp    = 6'b111111;
  localparam logic [2:0]   DrainLast = 3'(drainCycles);
  localparam logic [m-1:0] PcOne     = m'(1);

  fetchStateT   state, stateNext;
  logic [m-1:0] pcQ, pcNext;
  ifidT         ifidQ, ifidNext;
  logic [2:0]   cntQ, cntNext;
  logic         haltedQ, haltedNext;

  logic         isHalt;
  logic [m-1:0] pcInc;
  logic [2:0]   cntInc;

  assign isHalt = (bus.instrIn[n-1 -: 6] == HaltOp);
  assign pcInc  = pcQ + PcOne;   // m-bit add, wraps at 2^m
  assign cntInc = cntQ + 3'd1;

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) state <= sRun;
    else     state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      sRun: begin
        if (bus.redirect)              stateNext = sRun;
        else if (!bus.stall && isHalt) stateNext = sDrain;
      end
      sDrain: begin
        // A redirect here means the halt word was on a wrong path.
        if (bus.redirect)                           stateNext = sRun;
        else if (!bus.stall && cntInc == DrainLast) stateNext = sHalted;
      end
      sHalted: stateNext = sHalted;
      default: stateNext = sRun;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    pcNext     = pcQ;
    ifidNext   = ifidQ;
    cntNext    = cntQ;
    haltedNext = haltedQ;
    case (state)
      sRun, sDrain: begin
        if (bus.redirect) begin
          // Squash: bubble keeps the old ifidPc, redirect beats stall.
          pcNext         = bus.redirectTarget;
          ifidNext.instr = '0;
          ifidNext.valid = 1'b0;
          cntNext        = 3'd0;
        end else if (!bus.stall) begin
          if (state == sRun) begin
            ifidNext = '{instr: bus.instrIn, pcPlus1: pcInc, valid: 1'b1};
            cntNext  = 3'd0;
            // PC parks on the halt word so a later redirect is the only way on.
            if (!isHalt) pcNext = pcInc;
          end else begin
            ifidNext.instr = '0;
            ifidNext.valid = 1'b0;
            cntNext        = cntInc;
            if (cntInc == DrainLast) haltedNext = 1'b1;
          end
        end
      end
      sHalted: begin
        ifidNext.instr = '0;
        ifidNext.valid = 1'b0;
        haltedNext     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pcQ     <= '0;
      ifidQ   <= '0;
      cntQ    <= 3'd0;
      haltedQ <= 1'b0;
    end else begin
      pcQ     <= pcNext;
      ifidQ   <= ifidNext;
      cntQ    <= cntNext;
      haltedQ <= haltedNext;
    end
  end

  assign bus.pc        = pcQ;
  assign bus.ifidInstr = ifidQ.instr;
  assign bus.ifidPc    = ifidQ.pcPlus1;
  assign bus.ifidValid = ifidQ.valid;
  assign bus.halted    = haltedQ;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
  localparam int N     = 32;
  localparam int M     = 6;
  localparam int DRAIN = 4;
  localparam int WORDS = 2**M;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  instruction_fetch_if #(.n(N), .m(M)) bus();
  instruction_fetch #(.n(N), .m(M), .drainCycles(DRAIN)) dut (
    .Clk(Clk), .Rst(Rst), .bus(bus)
  );

  logic [N-1:0] mem [WORDS];
  assign bus.instrIn = mem[bus.pc];

  // Reference model: fetch pointer, IF/ID contents, bubbles still owed.
  int           mPc, mIfPc, drainLeft;
  logic [N-1:0] mInstr;
  bit           mValid, mHalted;
  int           nCmp = 0;
  int           nErr = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mPc = 0; mIfPc = 0; mInstr = '0; mValid = 0; mHalted = 0; drainLeft = 0;
  endtask

  task automatic modelEdge(bit rst, bit st, bit rd, int tgt);
    logic [N-1:0] w;
    if (rst) modelReset();
    else if (mHalted) begin
      mInstr = '0; mValid = 0;
    end else if (rd) begin
      mPc = tgt; mInstr = '0; mValid = 0; drainLeft = 0;
    end else if (st) begin
      // everything holds
    end else if (drainLeft > 0) begin
      mInstr = '0; mValid = 0;
      drainLeft--;
      if (drainLeft == 0) mHalted = 1;
    end else begin
      w      = mem[mPc];
      mInstr = w;
      mIfPc  = (mPc + 1) % WORDS;
      mValid = 1;
      if (w[N-1 -: 6] == 6'h3f) drainLeft = DRAIN;
      else                      mPc = (mPc + 1) % WORDS;
    end
  endtask

  task automatic checkAll(string tag);
    chk({tag, ".pc"},        64'(bus.pc),        64'(mPc));
    chk({tag, ".ifidInstr"}, 64'(bus.ifidInstr), 64'(mInstr));
    chk({tag, ".ifidPc"},    64'(bus.ifidPc),    64'(mIfPc));
    chk({tag, ".ifidValid"}, 64'(bus.ifidValid), 64'(mValid));
    chk({tag, ".halted"},    64'(bus.halted),    64'(mHalted));
  endtask

  task automatic step(bit rst, bit st, bit rd, int tgt, string tag);
    @(negedge Clk);
    Rst = rst; bus.stall = st; bus.redirect = rd; bus.redirectTarget = M'(tgt);
    @(posedge Clk);
    modelEdge(rst, st, rd, tgt);
    #1;
    checkAll(tag);
  endtask

  task automatic run(int k, string tag);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0, tag);
  endtask

  initial begin
    Rst = 1'b1; bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirectTarget = '0;
    for (int i = 0; i < WORDS; i++) mem[i] = N'(i + 100);
    modelReset();

    step(1, 0, 0, 0, "rst");
    step(1, 0, 0, 0, "rst");
    chk("rst.pc", 64'(bus.pc), 0);
    chk("rst.valid", 64'(bus.ifidValid), 0);

    // Straight-line fetch
    run(3, "seq");
    chk("seq.pc3", 64'(bus.pc), 3);
    chk("seq.instr102", 64'(bus.ifidInstr), 102);
    chk("seq.ifidPc3", 64'(bus.ifidPc), 3);
    run(1, "seq");

    // Two-cycle stall at pc=4
    step(0, 1, 0, 0, "stall");
    step(0, 1, 0, 0, "stall");
    chk("stall.pc4", 64'(bus.pc), 4);
    chk("stall.instr103", 64'(bus.ifidInstr), 103);
    run(1, "stall");
    chk("stall.release104", 64'(bus.ifidInstr), 104);

    // Redirect beats stall at pc=7
    run(2, "seq");
    step(0, 1, 1, 2, "redir");
    chk("redir.pc2", 64'(bus.pc), 2);
    chk("redir.bubble", 64'(bus.ifidValid), 0);
    run(1, "redir");
    chk("redir.instr102", 64'(bus.ifidInstr), 102);
    chk("redir.ifidPc3", 64'(bus.ifidPc), 3);

    // Halt word at address 8
    mem[8] = 32'hFC00_0000;
    run(5, "toHalt");
    run(1, "haltLatch");
    chk("halt.instr", 64'(bus.ifidInstr), 64'h00FC00_0000);
    chk("halt.ifidPc9", 64'(bus.ifidPc), 9);
    chk("halt.pc8", 64'(bus.pc), 8);
    run(3, "drain");
    chk("drain.notYet", 64'(bus.halted), 0);
    run(1, "drain");
    chk("drain.halted", 64'(bus.halted), 1);
    step(0, 0, 1, 5, "halted.redir");
    step(0, 1, 0, 0, "halted.stall");
    chk("halted.pcFrozen", 64'(bus.pc), 8);
    chk("halted.sticky", 64'(bus.halted), 1);

    // Redirect during DRAIN cancels the halt
    step(1, 0, 0, 0, "rst");
    run(8, "toHalt2");
    run(1, "haltLatch2");
    run(1, "drain2");
    step(0, 0, 1, 2, "cancel");
    chk("cancel.pc2", 64'(bus.pc), 2);
    chk("cancel.notHalted", 64'(bus.halted), 0);
    run(1, "cancel");
    chk("cancel.instr102", 64'(bus.ifidInstr), 102);

    // Wrap at top of memory
    step(0, 0, 1, 63, "wrap");
    chk("wrap.pc63", 64'(bus.pc), 63);
    run(1, "wrap");
    chk("wrap.pc0", 64'(bus.pc), 0);
    run(1, "wrap");
    chk("wrap.pc1", 64'(bus.pc), 1);

    // Reset mid-DRAIN
    run(7, "toHalt3");
    run(1, "haltLatch3");
    run(1, "drain3");
    step(1, 0, 0, 0, "rstDrain");
    chk("rstDrain.pc0", 64'(bus.pc), 0);
    chk("rstDrain.halted0", 64'(bus.halted), 0);
    chk("rstDrain.valid0", 64'(bus.ifidValid), 0);

    // Random program and control traffic
    for (int i = 0; i < WORDS; i++) begin
      mem[i] = $urandom;
      if ($urandom_range(0, 11) == 0) mem[i][N-1 -: 6] = 6'h3f;
      else if (mem[i][N-1 -: 6] == 6'h3f) mem[i][N-1] = 1'b0;
    end
    step(1, 0, 0, 0, "rnd.rst");
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0), int'($urandom_range(0, WORDS - 1)), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch stage of the pipelined CPU. Drives the instruction read address of the shared instruction/data memory, which has an asynchronous read, and latches the returned word into the IF/ID pipeline register. It handles:
- stalls from hazard detection,
- PC redirects from branch/jump resolution,
- detection of the end-of-program word (opcode 6'b111111), after which it drains the pipeline and raises `halted`.

## Interface
Parameters:
- `n`, 32, instruction width in bits
- `m`, 6, instruction address width; memory holds 2^m words
- `drainCycles`, 4, bubble cycles issued after the halt word before `halted` asserts (1..7)

Ports:
- `Clk`  in  1  clock; all state updates on posedge
- `Rst`  in  1  reset, synchronous, active-high
- `pc`  out  m  fetch address, wired to memory `instructionReadReg`
- `instrIn`  in  n  memory `readInstruction`, valid in the same cycle as `pc`
- `stall`  in  1  hold PC and IF/ID contents
- `redirect`  in  1  load PC from `redirectTarget` and squash IF/ID
- `redirectTarget`  in  m  new fetch address
- `ifidInstr`  out  n  latched instruction; 0 when bubble
- `ifidPc`  out  m  address of latched instruction + 1, modulo 2^m
- `ifidValid`  out  1  IF/ID holds a real instruction
- `halted`  out  1  program finished; sticky until reset

## Operation
State machine has three states: RUN, DRAIN, HALTED. A 3-bit drain counter runs in DRAIN.

Per-cycle priority is: Rst > redirect > state action.

Rst:
- `pc` = 0, `ifidInstr` = 0, `ifidPc` = 0, `ifidValid` = 0, `halted` = 0.
- State = RUN, drain counter = 0.

redirect (in RUN or DRAIN; ignored in HALTED):
- `pc` <= `redirectTarget`.
- IF/ID <= bubble: instr 0, valid 0, `ifidPc` unchanged.
- State <= RUN, counter cleared.
- Wins over `stall` in the same cycle.

RUN, `stall` = 1: all registers hold.

RUN, `stall` = 0, `instrIn[n-1:n-6]` != 6'b111111:
- IF/ID <= {`instrIn`, `pc`+1, valid 1}.
- `pc` <= `pc`+1. Arithmetic is m bits, so 2^m-1 wraps to 0.

RUN, `stall` = 0, halt word:
- IF/ID <= {`instrIn`, `pc`+1, valid 1}.
- `pc` is NOT incremented.
- State <= DRAIN, counter <= 0.

DRAIN:
- `pc` frozen.
- `stall` = 1: IF/ID holds and the counter holds.
- `stall` = 0: IF/ID <= bubble and the counter increments.
- When the counter reaches `drainCycles`: state <= HALTED and `halted` <= 1.

DRAIN exists because the halt word may be on a wrong path behind an unresolved branch. A redirect during DRAIN cancels the halt.

HALTED:
- IF/ID = bubble, `pc` frozen, `halted` = 1.
- `stall` and `redirect` are ignored. Only `Rst` exits.

## Timing
- Fetch-to-IF/ID latency: 1 cycle. The word at address A appears on `ifidInstr` on the posedge after the cycle where `pc` = A and `stall` = 0.
- Throughput: 1 instruction per cycle without stalls.
- Redirect penalty: exactly 1 bubble cycle, then `redirectTarget`'s word is latched on the following edge.
- `halted` rises `drainCycles` unstalled cycles after the edge that latched the halt word.
- All outputs are registered. No combinational path exists from `stall`, `redirect` or `instrIn` to any output.
- `Rst` asserted in any state, including mid-DRAIN or HALTED, restores reset values on the next edge.

## Test plan
- Reset, memory word k = k+100: after `Rst` deasserts, `pc` = 0 and `ifidValid` = 0. After 3 edges, `pc` = 3, `ifidInstr` = 102, `ifidPc` = 3, `ifidValid` = 1.
- `stall` high for 2 cycles while `pc` = 4: `pc` stays 4 and IF/ID stays at word 3 for both cycles. The cycle after release latches word 4.
- At `pc` = 7, drive `redirect` = 1, `redirectTarget` = 2 and `stall` = 1 together: next edge gives `pc` = 2, `ifidValid` = 0. The following edge gives `ifidInstr` = 102, `ifidPc` = 3.
- Word 8 = 0xFC000000:
  - IF/ID latches 0xFC000000 with valid 1 and `ifidPc` = 9, while `pc` stays 8.
  - Then 4 bubbles follow, and `halted` = 1 on the 4th.
  - Further redirect or stall changes nothing.
- Redirect to 2 on the 2nd DRAIN cycle: state returns to RUN, `halted` stays 0, and fetch resumes at 2.
- Redirect to 63 with no stalls: `pc` sequence is 63, 0, 1. Then assert `Rst` mid-DRAIN: next edge gives `pc` = 0, `halted` = 0, `ifidValid` = 0.
